// File: rtl/onchip_mem_fill_check_master_if.sv
// onchip_mem_fill_check_master_if: Avalon-MM on-chip RAM port (read latency 1).
interface onchip_mem_fill_check_master_if #(parameter int ADDR_W = 14);
   logic [ADDR_W-1:0] address;
   logic [3:0] byteenable;
   logic chipselect;
   logic write;
   logic [31:0] writedata;
   logic clken;
   logic [31:0] readdata;
   modport master(output address, byteenable, chipselect, write, writedata, clken, input readdata);
   modport slave(input address, byteenable, chipselect, write, writedata, clken, output readdata);
endinterface

// File: rtl/onchip_mem_fill_check_master.sv
// onchip_mem_fill_check_master: fills a RAM word range with seed+i, reads it back and
// reports pass/fail, saturating mismatch count and first failing address.
module onchip_mem_fill_check_master #(
   parameter int ADDR_W = 14,
   parameter int DEPTH = 10240,
   parameter int CNT_W = 14
) (
   input logic clk,
   input logic reset,
   input logic start,
   input logic abort,
   input logic [ADDR_W-1:0] base_addr,
   input logic [CNT_W-1:0] word_count,
   input logic [31:0] seed,
   onchip_mem_fill_check_master_if.master mem,
   output logic busy,
   output logic done,
   output logic pass,
   output logic range_err,
   output logic [CNT_W-1:0] fail_count,
   output logic [ADDR_W-1:0] first_fail_addr
);
   localparam int SW = (ADDR_W > CNT_W ? ADDR_W : CNT_W) + 1;
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] base, exp_addr;
   logic [CNT_W-1:0] cnt, idx, fail_nxt;
   logic [31:0] sd, exp_data;
   logic [SW-1:0] range_end;
   logic cmp_valid, bad_range, last, mismatch;
   assign range_end = SW'(base_addr) + SW'(word_count);
   assign bad_range = range_end > SW'(DEPTH);
   assign last = idx == cnt - CNT_W'(1);
   // an abort cycle discards whatever compare is in flight
   assign mismatch = cmp_valid && !abort && (mem.readdata != exp_data);
   assign fail_nxt = (mismatch && fail_count != '1) ? fail_count + CNT_W'(1) : fail_count;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (word_count == '0 || bad_range) ? DONE : WRITE;
         WRITE: state_nxt = abort ? IDLE : last ? READ : WRITE;
         READ: state_nxt = abort ? IDLE : last ? DRAIN : READ;
         DRAIN: state_nxt = abort ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   assign busy = state == WRITE || state == READ || state == DRAIN;
   assign done = state == DONE;
   assign mem.chipselect = state == WRITE || state == READ;
   assign mem.write = state == WRITE;
   assign mem.byteenable = mem.chipselect ? 4'hF : 4'h0;
   assign mem.clken = busy;
   assign mem.address = mem.chipselect ? base + ADDR_W'(idx) : '0;
   assign mem.writedata = mem.write ? sd + 32'(idx) : '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base <= '0;
         cnt <= '0;
         sd <= '0;
         idx <= '0;
         exp_data <= '0;
         exp_addr <= '0;
         cmp_valid <= 1'b0;
         fail_count <= '0;
         first_fail_addr <= '0;
         pass <= 1'b0;
         range_err <= 1'b0;
      end else begin
         cmp_valid <= state == READ && !abort;
         exp_data <= sd + 32'(idx);
         exp_addr <= base + ADDR_W'(idx);
         fail_count <= fail_nxt;
         if (mismatch && fail_count == '0) first_fail_addr <= exp_addr;
         if (state == WRITE || state == READ) idx <= (last || abort) ? '0 : idx + CNT_W'(1);
         if (state == DRAIN) pass <= !abort && fail_nxt == '0;
         if (busy && abort) pass <= 1'b0;
         if (state == IDLE && start) begin
            base <= base_addr;
            cnt <= word_count;
            sd <= seed;
            idx <= '0;
            fail_count <= '0;
            first_fail_addr <= '0;
            range_err <= word_count != '0 && bad_range;
            pass <= word_count == '0;
         end
      end
   end
endmodule
